i2c_scl_timer: RTL and testbench

Parametrised SCL bit-timing generator for the I2C master, superseding the fixed single-state stretch counter. It drives the open-drain SCL enable through programmable low and high phases. It detects slave clock stretching and extends the high phase for its duration, and flags a stretch timeout. It sits between the byte/bit controller (which supplies `en` and consumes the tick/done pulses) and the SCL pad.

---
 rtl/i2c_scl_timer.sv | 174 +++++++++++++++++
 tb/tb_i2c_scl_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_timer.sv
// i2c_scl_timer: SCL bit-timing generator for the I2C master.
// Sequences each bit as LOW -> WAIT_HIGH -> HIGH.
// WAIT_HIGH absorbs slave clock stretching and can give up with a sticky timeout.
// All outputs are registered from the next-state decode, so they line up
// with the state the block is in during the same cycle.
module i2c_scl_timer #(
  parameter int CNT_W = 16,
  parameter int TO_W  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] low_cnt,
  input  logic [CNT_W-1:0] high_cnt,
  input  logic             stretch_en,
  input  logic             scl_in,
  input  logic [TO_W-1:0]  to_limit,
  input  logic             to_clr,
  output logic             scl_oe,
  output logic             sda_tick,
  output logic             sample_tick,
  output logic             bit_done,
  output logic             stretching,
  output logic             timeout,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HIGH = 2'd3;

  // Phase lengths shorter than two cycles would collapse the mid-phase tick
  // onto the phase edges, so they are raised to two.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
    if (len < CNT_W'(2)) begin
      clamp_len = CNT_W'(2);
    end else begin
      clamp_len = len;
    end
  endfunction

  // Stretch counter saturates instead of wrapping so a disabled timeout never
  // sees a false small count.
  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] val);
    if (val == {TO_W{1'b1}}) begin
      sat_inc = val;
    end else begin
      sat_inc = val + TO_W'(1);
    end
  endfunction

  logic [1:0]       state_r,    state_s;
  logic [CNT_W-1:0] cnt_r,      cnt_s;
  logic [CNT_W-1:0] low_len_r,  low_len_s;
  logic [CNT_W-1:0] high_len_r, high_len_s;
  logic [TO_W-1:0]  stretch_r,  stretch_s;
  logic             timeout_s;
  logic             stretch_obs_s;
  logic             scl_oe_s, sda_tick_s, sample_tick_s, bit_done_s, busy_s;

  // Next-state, phase counter, latched lengths, stretch counter and timeout flag.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    low_len_s     = low_len_r;
    high_len_s    = high_len_r;
    stretch_s     = stretch_r;
    stretch_obs_s = 1'b0;
    if (to_clr) begin
      timeout_s = 1'b0;
    end else begin
      timeout_s = timeout;
    end
    case (state_r)
      ST_IDLE: begin
        cnt_s     = {CNT_W{1'b0}};
        stretch_s = {TO_W{1'b0}};
        if (en && !timeout) begin
          state_s   = ST_LOW;
          low_len_s = clamp_len(low_cnt);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (cnt_r == low_len_r - CNT_W'(1)) begin
          state_s = ST_WAIT;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (scl_in || !stretch_en) begin
          state_s    = ST_HIGH;
          cnt_s      = {CNT_W{1'b0}};
          high_len_s = clamp_len(high_cnt);
          stretch_s  = {TO_W{1'b0}};
        end else begin
          stretch_obs_s = 1'b1;
          stretch_s     = sat_inc(stretch_r);
          if ((to_limit != {TO_W{1'b0}}) && (stretch_s >= to_limit)) begin
            // Setting the flag overrides a coincident clear.
            state_s   = ST_IDLE;
            stretch_s = {TO_W{1'b0}};
            timeout_s = 1'b1;
          end else begin
            state_s = ST_WAIT;
          end
        end
      end
      ST_HIGH: begin
        if (cnt_r == high_len_r - CNT_W'(1)) begin
          cnt_s = {CNT_W{1'b0}};
          if (en && !timeout) begin
            state_s   = ST_LOW;
            low_len_s = clamp_len(low_cnt);
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s   = ST_IDLE;
        cnt_s     = {CNT_W{1'b0}};
        stretch_s = {TO_W{1'b0}};
      end
    endcase
  end

  // Output decode from the next state so registered outputs match the state.
  always_comb begin
    scl_oe_s      = (state_s == ST_LOW);
    busy_s        = (state_s != ST_IDLE);
    sda_tick_s    = (state_s == ST_LOW)  && (cnt_s == (low_len_s >> 1));
    sample_tick_s = (state_s == ST_HIGH) && (cnt_s == (high_len_s >> 1));
    bit_done_s    = (state_s == ST_HIGH) && (cnt_s == high_len_s - CNT_W'(1));
  end

  // State, counters and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      low_len_r   <= {CNT_W{1'b0}};
      high_len_r  <= {CNT_W{1'b0}};
      stretch_r   <= {TO_W{1'b0}};
      timeout     <= 1'b0;
      scl_oe      <= 1'b0;
      sda_tick    <= 1'b0;
      sample_tick <= 1'b0;
      bit_done    <= 1'b0;
      stretching  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      low_len_r   <= low_len_s;
      high_len_r  <= high_len_s;
      stretch_r   <= stretch_s;
      timeout     <= timeout_s;
      scl_oe      <= scl_oe_s;
      sda_tick    <= sda_tick_s;
      sample_tick <= sample_tick_s;
      bit_done    <= bit_done_s;
      stretching  <= stretch_obs_s;
      busy        <= busy_s;
    end
  end

endmodule

// File: tb/tb_i2c_scl_timer.sv
// tb_i2c_scl_timer: scoreboard bench for i2c_scl_timer.
// Stimulus pushes time-stamped expected events (ticks, SCL edges, stretch
// edges, timeout rise); a negedge monitor pops and compares them as they occur.
module tb_i2c_scl_timer;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] low_cnt;
  logic [15:0] high_cnt;
  logic        stretch_en;
  logic        scl_in;
  logic [19:0] to_limit;
  logic        to_clr;
  logic        scl_oe, sda_tick, sample_tick, bit_done, stretching, timeout, busy;

  // slave model controls
  logic        stuck;
  int          stretch_cycles;
  int          rel_cnt;
  int          cyc;

  int          errors;
  int          checks;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
  } ev_t;
  ev_t sb[$];

  logic oe_q, str_q, to_q;

  i2c_scl_timer #(.CNT_W(16), .TO_W(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .low_cnt     (low_cnt),
    .high_cnt    (high_cnt),
    .stretch_en  (stretch_en),
    .scl_in      (scl_in),
    .to_limit    (to_limit),
    .to_clr      (to_clr),
    .scl_oe      (scl_oe),
    .sda_tick    (sda_tick),
    .sample_tick (sample_tick),
    .bit_done    (bit_done),
    .stretching  (stretching),
    .timeout     (timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Open-drain line: low while driven, or while the slave holds it after release.
  assign scl_in = stuck ? 1'b0 : (!scl_oe && (rel_cnt >= stretch_cycles));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (scl_oe) rel_cnt <= 0;
    else        rel_cnt <= rel_cnt + 1;
  end

  function automatic string kname(input logic [2:0] k);
    case (k)
      3'd0:    kname = "sda_tick";
      3'd1:    kname = "sample_tick";
      3'd2:    kname = "bit_done";
      3'd3:    kname = "scl_oe_rise";
      3'd4:    kname = "scl_oe_fall";
      3'd5:    kname = "stretching_rise";
      3'd6:    kname = "stretching_fall";
      default: kname = "timeout_rise";
    endcase
  endfunction

  task automatic push(input logic [2:0] k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // One bit starting its LOW phase at cycle s: low l, high h, stretch st.
  task automatic exp_bit(input int s, input int l, input int h, input int st);
    push(3'd3, s);
    push(3'd0, s + l / 2);
    push(3'd4, s + l);
    if (st > 0) begin
      push(3'd5, s + l + 1);
      push(3'd6, s + l + st + 1);
    end
    push(3'd1, s + l + 1 + st + h / 2);
    push(3'd2, s + l + st + h);
  endtask

  task automatic got(input logic [2:0] k);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL event: got %s at cycle %0d, required none", kname(k), cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind !== k || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                 kname(k), cyc, kname(e.kind), e.cyc);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: every observed pulse or edge is matched against the scoreboard.
  always @(negedge clk) begin
    if (sda_tick)               got(3'd0);
    if (sample_tick)            got(3'd1);
    if (bit_done)               got(3'd2);
    if (scl_oe && !oe_q)        got(3'd3);
    if (!scl_oe && oe_q)        got(3'd4);
    if (stretching && !str_q)   got(3'd5);
    if (!stretching && str_q)   got(3'd6);
    if (timeout && !to_q)       got(3'd7);
    if (sda_tick || sample_tick || bit_done)
      chk("pulse_exclusive", 32'($countones({sda_tick, sample_tick, bit_done})), 32'd1);
    oe_q  <= scl_oe;
    str_q <= stretching;
    to_q  <= timeout;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int s;
    errors = 0; checks = 0; cyc = 0; rel_cnt = 0;
    oe_q = 1'b0; str_q = 1'b0; to_q = 1'b0;
    reset = 1'b0; en = 1'b1; low_cnt = 16'd8; high_cnt = 16'd8;
    stretch_en = 1'b1; to_limit = 20'd0; to_clr = 1'b0;
    stuck = 1'b0; stretch_cycles = 0;

    // reset held with en high: everything quiet
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {25'd0, scl_oe, sda_tick, sample_tick, bit_done,
                          stretching, timeout, busy}, 32'd0);

    // release with en high, three nominal back-to-back bits, en dropped mid-LOW
    c = cyc; reset = 1'b1; s = c + 1;
    exp_bit(s, 8, 8, 0);
    exp_bit(s + 17, 8, 8, 0);
    exp_bit(s + 34, 8, 8, 0);
    wait_to(s + 36); en = 1'b0;
    wait_to(s + 53);
    chk("idle_after_nominal", {30'd0, busy, scl_oe}, 32'd0);

    // slave stretches for 20 cycles
    c = cyc; stretch_cycles = 20; en = 1'b1; s = c + 1;
    exp_bit(s, 8, 8, 20);
    wait_to(s + 2); en = 1'b0;
    wait_to(s + 40);
    chk("idle_after_stretch", {30'd0, busy, timeout}, 32'd0);
    stretch_cycles = 0;

    // stuck line with a 50-cycle limit
    c = cyc; to_limit = 20'd50; stuck = 1'b1; en = 1'b1; s = c + 1;
    push(3'd3, s); push(3'd0, s + 4); push(3'd4, s + 8);
    push(3'd5, s + 9); push(3'd7, s + 58); push(3'd6, s + 59);
    wait_to(s + 70);
    chk("timeout_idle", {29'd0, busy, timeout, scl_oe}, 32'd2);
    c = cyc; stuck = 1'b0; to_clr = 1'b1;
    wait_to(c + 1); to_clr = 1'b0;
    chk("timeout_cleared", {30'd0, busy, timeout}, 32'd0);
    s = c + 2;
    exp_bit(s, 8, 8, 0);
    wait_to(s + 2); en = 1'b0;
    wait_to(s + 20);
    chk("idle_after_clear", {30'd0, busy, timeout}, 32'd0);

    // stretching ignored when disabled
    c = cyc; stretch_en = 1'b0; stuck = 1'b1; en = 1'b1; s = c + 1;
    exp_bit(s, 8, 8, 0);
    wait_to(s + 2); en = 1'b0;
    wait_to(s + 20);
    chk("idle_after_nostretch", {30'd0, busy, stretching}, 32'd0);
    stuck = 1'b0; stretch_en = 1'b1;

    // low_cnt of 1 acts as 2; a mid-LOW change to low_cnt has no effect
    c = cyc; low_cnt = 16'd1; en = 1'b1; s = c + 1;
    exp_bit(s, 2, 8, 0);
    wait_to(s + 1); low_cnt = 16'd8; en = 1'b0;
    wait_to(s + 14);
    chk("idle_after_short_low", {31'd0, busy}, 32'd0);

    // high_cnt 8 -> 4 mid-HIGH applies to the following bit only
    c = cyc; en = 1'b1; s = c + 1;
    exp_bit(s, 8, 8, 0);
    exp_bit(s + 17, 8, 4, 0);
    wait_to(s + 11); high_cnt = 16'd4;
    wait_to(s + 19); en = 1'b0;
    wait_to(s + 33);
    chk("idle_after_high_change", {30'd0, busy, scl_oe}, 32'd0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
